// File: rtl/rv32_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32_instr_encoder
//
// Turns a decoded instruction request (class, funct3, alt flag, register
// indices, immediate) into a 32-bit RV32IM machine word. Each encoded word is
// tagged with a sequential instruction-memory byte address and handed to a
// downstream SRAM writer over a valid/ready handshake.
//
// The output stage holds a single word and forms a two-state FSM:
// EMPTY or FULL. A request is taken whenever the stage is EMPTY or is being
// drained in the same cycle, so the encoder can sustain one word per cycle.
// A request that cannot be encoded is replaced by a NOP (addi x0,x0,0) and
// flagged, and the error is remembered until the next reset or base load.
//
// Ports
//   clk         single clock
//   rst         synchronous, active-high reset (highest priority)
//   base_load   load the address counter from base_addr (blocks accepts)
//   base_addr   start byte address; bits [1:0] are forced to zero
//   req_valid   an encode request is present
//   req_ready   the request is accepted this cycle
//   req_class   0 LUI 1 AUIPC 2 JAL 3 JALR 4 BRANCH 5 LOAD 6 STORE
//               7 OP_IMM 8 OP_REG 9 MEXT 10 FENCE 11 ECALL 12 EBREAK
//   req_funct3  funct3 field value
//   req_alt     selects SUB / SRA / SRAI (funct7 = 0100000)
//   req_rd      destination register index
//   req_rs1     first source register index
//   req_rs2     second source register index
//   req_imm     signed immediate (full value for U-type)
//   out_valid   out_instr/out_addr/out_err carry a word
//   out_ready   downstream accepts the word
//   out_instr   encoded instruction word
//   out_addr    byte address of out_instr
//   out_err     this word is a NOP substituted for a bad request
//   err_sticky  an error occurred since the last rst or base_load
// ---------------------------------------------------------------------------
module rv32_instr_encoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_class,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky
);

    // Request classes
    localparam logic [3:0] CLS_LUI    = 4'd0;
    localparam logic [3:0] CLS_AUIPC  = 4'd1;
    localparam logic [3:0] CLS_JAL    = 4'd2;
    localparam logic [3:0] CLS_JALR   = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_LOAD   = 4'd5;
    localparam logic [3:0] CLS_STORE  = 4'd6;
    localparam logic [3:0] CLS_OP_IMM = 4'd7;
    localparam logic [3:0] CLS_OP_REG = 4'd8;
    localparam logic [3:0] CLS_MEXT   = 4'd9;
    localparam logic [3:0] CLS_FENCE  = 4'd10;
    localparam logic [3:0] CLS_ECALL  = 4'd11;
    localparam logic [3:0] CLS_EBREAK = 4'd12;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Fixed words
    localparam logic [31:0] WORD_NOP    = 32'h0000_0013;
    localparam logic [31:0] WORD_FENCE  = 32'h0FF0_000F;
    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } enc_t;

    // Inclusive signed range test used by every immediate format.
    function automatic logic in_range(
        input logic signed [31:0] value,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        return (value >= lo) && (value <= hi);
    endfunction

    // Immediate legality per format. B and J offsets address 16-bit
    // parcels, so bit 0 must be clear.
    function automatic logic imm_ok_i(input logic [31:0] imm);
        return in_range(signed'(imm), -32'sd2048, 32'sd2047);
    endfunction

    function automatic logic imm_ok_b(input logic [31:0] imm);
        return in_range(signed'(imm), -32'sd4096, 32'sd4094) && !imm[0];
    endfunction

    function automatic logic imm_ok_j(input logic [31:0] imm);
        return in_range(signed'(imm), -32'sd1048576, 32'sd1048574) && !imm[0];
    endfunction

    function automatic logic imm_ok_u(input logic [31:0] imm);
        return imm[11:0] == 12'h000;
    endfunction

    // Shift amounts are unsigned 0..31: any higher bit set is out of range.
    function automatic logic imm_ok_shamt(input logic [31:0] imm);
        return imm[31:5] == 27'h0;
    endfunction

    // Field packing per base format
    function automatic logic [31:0] pack_r(
        input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc
    );
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] pack_i(
        input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] opc
    );
        return {imm[11:0], rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] pack_s(
        input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [6:0] opc
    );
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    function automatic logic [31:0] pack_b(
        input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [6:0] opc
    );
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
    endfunction

    function automatic logic [31:0] pack_u(
        input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] opc
    );
        return {imm[31:12], rd, opc};
    endfunction

    function automatic logic [31:0] pack_j(
        input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] opc
    );
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
    endfunction

    // Full encoder: selects the format for the class, checks legality and
    // substitutes a NOP when the request is illegal or out of range.
    function automatic enc_t encode(
        input logic [3:0]  cls,
        input logic [2:0]  f3,
        input logic        alt,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        enc_t       res;
        logic       bad;
        logic [6:0] f7;
        res.word = WORD_NOP;
        res.err  = 1'b0;
        bad      = 1'b0;
        f7       = alt ? F7_ALT : F7_BASE;
        case (cls)
            CLS_LUI: begin
                bad      = !imm_ok_u(imm);
                res.word = pack_u(imm, rd, OPC_LUI);
            end
            CLS_AUIPC: begin
                bad      = !imm_ok_u(imm);
                res.word = pack_u(imm, rd, OPC_AUIPC);
            end
            CLS_JAL: begin
                bad      = !imm_ok_j(imm);
                res.word = pack_j(imm, rd, OPC_JAL);
            end
            CLS_JALR: begin
                // funct3 is architecturally fixed at 000 for JALR
                bad      = !imm_ok_i(imm);
                res.word = pack_i(imm, rs1, 3'b000, rd, OPC_JALR);
            end
            CLS_BRANCH: begin
                bad      = !imm_ok_b(imm) || (f3 inside {3'b010, 3'b011});
                res.word = pack_b(imm, rs2, rs1, f3, OPC_BRANCH);
            end
            CLS_LOAD: begin
                bad      = !imm_ok_i(imm) || (f3 inside {3'b011, 3'b110, 3'b111});
                res.word = pack_i(imm, rs1, f3, rd, OPC_LOAD);
            end
            CLS_STORE: begin
                bad      = !imm_ok_i(imm) || (f3 > 3'b010);
                res.word = pack_s(imm, rs2, rs1, f3, OPC_STORE);
            end
            CLS_OP_IMM: begin
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    // Shift-immediate: the upper immediate bits carry funct7,
                    // and only SRAI (funct3 101) may use the alt form.
                    bad      = !imm_ok_shamt(imm) || (alt && (f3 != 3'b101));
                    res.word = pack_r(f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM);
                end else begin
                    bad      = !imm_ok_i(imm) || alt;
                    res.word = pack_i(imm, rs1, f3, rd, OPC_OP_IMM);
                end
            end
            CLS_OP_REG: begin
                bad      = alt && !(f3 inside {3'b000, 3'b101});
                res.word = pack_r(f7, rs2, rs1, f3, rd, OPC_OP);
            end
            CLS_MEXT: begin
                res.word = pack_r(F7_MEXT, rs2, rs1, f3, rd, OPC_OP);
            end
            CLS_FENCE:  res.word = WORD_FENCE;
            CLS_ECALL:  res.word = WORD_ECALL;
            CLS_EBREAK: res.word = WORD_EBREAK;
            default:    bad = 1'b1;
        endcase
        if (bad) begin
            res.word = WORD_NOP;
        end
        res.err = bad;
        return res;
    endfunction

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] counter;
    logic [31:0]       instr_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              err_p1;
    logic              sticky;
    logic              accept;
    logic              handshake;
    enc_t              enc_p0;
    logic              base_unused;

    // The two low address bits are always zero in the counter.
    assign base_unused = ^base_addr[1:0];

    // ---- stage p0: request decode / encode ----
    always_comb begin
        enc_p0 = encode(req_class, req_funct3, req_alt, req_rd, req_rs1,
                        req_rs2, req_imm);
    end

    // A slot is free when the stage is EMPTY or is being drained this cycle.
    assign req_ready = !rst && !base_load && ((state == EMPTY) || out_ready);
    assign accept    = req_valid && req_ready;
    assign handshake = (state == FULL) && out_ready;

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (handshake && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
        end else if (base_load) begin
            counter <= {base_addr[ADDR_W-1:2], 2'b00};
        end else if (accept) begin
            counter <= counter + ADDR_W'(4);
        end
    end

    // ---- stage p1: output word register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1 <= '0;
            addr_p1  <= '0;
            err_p1   <= 1'b0;
        end else if (accept) begin
            instr_p1 <= enc_p0.word;
            addr_p1  <= counter;
            err_p1   <= enc_p0.err;
        end
    end

    // base_load and accept are mutually exclusive, so clear and set never
    // collide.
    always_ff @(posedge clk) begin
        if (rst || base_load) begin
            sticky <= 1'b0;
        end else if (accept && enc_p0.err) begin
            sticky <= 1'b1;
        end
    end

    assign out_valid  = (state == FULL);
    assign out_instr  = instr_p1;
    assign out_addr   = addr_p1;
    assign out_err    = err_p1;
    assign err_sticky = sticky;

endmodule

// File: doc/rv32_instr_encoder.md
RV32_INSTR_ENCODER -- requirements
Module: rv32_instr_encoder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 16, giving the instruction-memory byte-address width.
REQ-002 The module SHALL have the port clk, input, 1 bit: the single clock.
REQ-003 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have the port base_load, input, 1 bit: load the address counter from base_addr.
REQ-005 The module SHALL have the port base_addr, input, ADDR_W bits: start byte address, with bits [1:0] ignored and treated as 0.
REQ-006 The module SHALL have the port req_valid, input, 1 bit: an encode request is present.
REQ-007 The module SHALL have the port req_ready, output, 1 bit: the encoder accepts the request this cycle.
REQ-008 The module SHALL have the port req_class, input, 4 bits: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP_REG, 9 MEXT, 10 FENCE, 11 ECALL, 12 EBREAK; values 13-15 are illegal.
REQ-009 The module SHALL have the port req_funct3, input, 3 bits: operation-select bits written into the instruction word's funct3 field.
REQ-010 The module SHALL have the port req_alt, input, 1 bit: selects SUB or SRA/SRAI, which sets funct7 = 0100000.
REQ-011 The module SHALL have the ports req_rd, req_rs1 and req_rs2, input, 5 bits each: register indices.
REQ-012 The module SHALL have the port req_imm, input, 32 bits: signed immediate; for U-type it is the full value, with the upper 20 bits used.
REQ-013 The module SHALL have the port out_valid, output, 1 bit: the output word is valid.
REQ-014 The module SHALL have the port out_ready, input, 1 bit: the downstream instruction-SRAM writer accepts the word.
REQ-015 The module SHALL have the port out_instr, output, 32 bits: the encoded RV32IM instruction.
REQ-016 The module SHALL have the port out_addr, output, ADDR_W bits: the byte address assigned to out_instr.
REQ-017 The module SHALL have the port out_err, output, 1 bit: the current word was substituted because of an encode error.
REQ-018 The module SHALL have the port err_sticky, output, 1 bit: an error has occurred since the last rst or base_load.

Function
REQ-019 The output stage SHALL be a two-state FSM, EMPTY (out_valid=0) or FULL (out_valid=1).
- EMPTY -> FULL on an accept.
- FULL -> EMPTY on an output handshake with no accept in the same cycle.
- FULL stays FULL on simultaneous handshake and accept.
REQ-020 The encoder SHALL assert req_ready = (EMPTY or out_ready) and not base_load.
REQ-021 An accept SHALL occur when req_valid and req_ready are both 1; the encoded word SHALL appear on out_instr on the next cycle, giving a latency of 1 cycle.
REQ-022 On accept, out_addr SHALL take the current counter value and the counter SHALL advance by 4, wrapping modulo 2^ADDR_W.
REQ-023 base_load SHALL set the counter to {base_addr[ADDR_W-1:2],2'b00}, clear err_sticky, and block accepts for that cycle; an already-FULL word keeps its address.
REQ-024 While FULL and out_ready=0, out_instr, out_addr and out_err SHALL hold stable.
REQ-025 Encoding SHALL follow the RV32I/M base formats exactly:
- LUI uses opcode 0110111.
- AUIPC uses 0010111.
- JAL uses 1101111.
- JALR uses 1100111 with funct3 000.
- BRANCH uses 1100011.
- LOAD uses 0000011.
- STORE uses 0100011.
- OP_IMM uses 0010011.
- OP_REG uses 0110011.
- MEXT uses 0110011 with funct7 0000001.
- FENCE SHALL encode as 0x0FF0000F.
- ECALL SHALL encode as 0x00000073.
- EBREAK SHALL encode as 0x00100073.
REQ-026 Immediate range checks SHALL be:
- I/S: -2048..2047.
- B: -4096..4094 and even.
- J: -1048576..1048574 and even.
- U: req_imm[11:0] must be 0.
- Shift-immediates (OP_IMM funct3 001/101): 0..31.
REQ-027 Illegal requests SHALL be:
- req_class 13-15.
- LOAD funct3 011, 110 or 111.
- STORE funct3 above 010.
- BRANCH funct3 010 or 011.
- req_alt=1 on OP_REG funct3 other than 000/101.
- req_alt=1 on OP_IMM funct3 other than 101.
REQ-028 On any range or illegal-request error, the encoder SHALL emit 0x00000013 (NOP), set out_err=1 for that word, and set err_sticky; the address still advances.
REQ-029 Fields unused by the chosen format SHALL be ignored; JALR SHALL ignore req_funct3.

Reset
REQ-030 While rst=1:
- out_valid=0, out_err=0, err_sticky=0.
- out_instr=0x00000000, out_addr=0.
- counter=0, req_ready=0.
REQ-031 rst asserted mid-operation SHALL discard any FULL word without a handshake.
REQ-032 rst SHALL take priority over base_load and accept.

Verification
REQ-033 The bench SHALL check: rst, then OP_IMM funct3 000 with rd=1, rs1=0, imm=5 -> out_instr=0x00500093, out_addr=0, and out_valid one cycle after the accept.
REQ-034 The bench SHALL check: OP_REG funct3 000 with rd=3, rs1=1, rs2=2, alt=0 then alt=1 -> 0x002081B3 then 0x402081B3, with addresses 0 and 4.
REQ-035 The bench SHALL check: MEXT funct3 000 with rd=5, rs1=6, rs2=7 -> 0x027302B3; STORE funct3 010 with rs1=1, rs2=2, imm=8 -> 0x0020A423; JAL with rd=1, imm=8 -> 0x008000EF.
REQ-036 The bench SHALL check: OP_IMM with imm=2048 -> out_instr=0x00000013, out_err=1, err_sticky=1; a following base_load clears err_sticky.
REQ-037 The bench SHALL check: base_load with base_addr=0xFFFC, then two accepts -> out_addr 0xFFFC then 0x0000 (wrap).
REQ-038 The bench SHALL check: FULL with out_ready held 0 for 5 cycles -> req_ready=0 and outputs stable; then out_ready=1 together with req_valid -> back-to-back handshake and accept, with the FSM staying FULL.
